aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencing controller and top-level core for the AES-128 encryption datapath. Owns the state and round-key registers, instantiates `keyexpansion`, `subbytes`, `shiftrows`, `mixcolumns` and `addroundkey`, and drives their enables and round index through one initial key addition and ten rounds. Sits directly below the SPI/host wrapper and presents a level `load` / `done` handshake.

## Interface
Parameters:
- `NROUNDS`, 10, number of AES rounds. Only 10, AES-128, is supported.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  start request, sampled on each rising edge.
- `key`  in  128  cipher key, MSB = byte 0; captured when `load` is accepted.
- `plaintext`  in  128  input block, MSB = byte 0; captured when `load` is accepted.
- `cyphertext`  out  128  result block; valid while `done` = 1.
- `done`  out  1  result valid.
- `busy`  out  1  encryption in progress.
- `round`  out  4  current round index, 0–10.

## Operation
States:
- **IDLE**
  - `load` = 1 latches `key` into `rk_q` and `plaintext ^ key` into `st_q`.
  - Sets `round` = 1 and moves to SUB.
- **SUB**
  - `subbytes` is enabled on `st_q`.
  - `keyexpansion` is driven with round index `round-1` on `rk_q`.
  - Both are registered inside those blocks with 1-cycle latency. Next state is MIX.
- **MIX**
  - `shiftrows` and `addroundkey` are always enabled.
  - `mixcolumns` is enabled only when `round` < 10. With its enable low it passes its input through unchanged.
  - Updates `st_q` with ARK(MC(SR(SB(st_q))), nextroundkey) and `rk_q` with `nextroundkey`.
  - If `round` = 10, moves to DONE. Otherwise increments `round` and returns to SUB.
- **DONE**
  - `done` = 1 and `cyphertext` = `st_q`, both held.
  - `load` = 1 starts a new encryption exactly as in IDLE: captures the inputs, drops `done` and goes to SUB.
  - `load` = 0 stays in DONE.

Outputs and handshake:
- `busy` = 1 in SUB and MIX.
- `round` = 0 in IDLE, and holds 10 in DONE.
- `load` is level-sensitive. A continuously high `load` in DONE restarts back-to-back encryptions.
- `key` and `plaintext` may change freely after the accepting edge.
- All data arithmetic is GF(2^8) inside the sub-blocks. The controller performs only XOR and 4-bit counter increments; the counter never exceeds 10.

## Timing
- Let E0 be the edge where `load` is accepted.
  - E1: first SUB.
  - Round r: SUB at E(2r−1), MIX at E(2r).
  - `done` rises after E20, i.e. 20 cycles after E0, 21 cycles including the accepting cycle.
- Throughput: one block per 21 cycles with `load` held high.
- Reset values:
  - `done` = 0, `busy` = 0, `round` = 0, `cyphertext` = 0.
  - `st_q` = 0, `rk_q` = 0, state = IDLE.
- `reset` has priority over everything. Reset mid-encryption aborts on that edge: the outputs above are 0 on the following cycle and no `done` pulse is produced.
- `load` in SUB or MIX: see Configuration.
- `reset` and `load` high together: reset wins, and `load` must be re-sampled in IDLE on a later edge.

## Configuration
- `AES_LOAD_ABORT_EN`
  - **Defined:** `load` = 1 in SUB or MIX aborts the current block, captures new `key`/`plaintext` as if in IDLE, and restarts timing from that edge (new E0). `done` stays 0.
  - **Undefined:** `load` is ignored while `busy` = 1, and the running encryption completes unaffected.

## Test plan
- **FIPS-197 Appendix B:** `key` = 2B7E151628AED2A6ABF7158809CF4F3C, `plaintext` = 3243F6A8885A308D313198A2E0370734, `load` pulsed one cycle → `done` after exactly 20 edges, `cyphertext` = 3925841D02DC09FBDC118597196A0B32, `busy` = 0 in DONE.
- **FIPS-197 C.1:** `key` = 000102030405060708090A0B0C0D0E0F, `plaintext` = 00112233445566778899AABBCCDDEEFF → `cyphertext` = 69C4E0D86A7B0430D8CDB78070B4C55A. Inputs are changed to random values one cycle after `load` and the result must not change.
- **Back-to-back:** hold `load` high across the B then C.1 vectors → two `done` phases, each one cycle long. `round` sequence 0,1,1,2,2,…,10,10,1…
- **Reset mid-op:** assert `reset` at `round` = 5 → next cycle `done` = 0, `busy` = 0, `round` = 0, `cyphertext` = 0. A following Appendix B run still yields 3925841D….
- **Load while busy, macro undefined:** pulse `load` with C.1 inputs at `round` = 3 → Appendix B result still produced on schedule.
- **Load while busy, macro defined:** same stimulus → `done` rises 20 edges after the abort edge with 69C4E0D8….

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption core: controller, state/round-key registers and round datapath.
// Optional build macro AES_LOAD_ABORT_EN lets load abort and restart a running block.
module aes_round_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] cyphertext,
    output logic         done,
    output logic         busy,
    output logic [3:0]   round
);

    localparam logic [3:0] LAST = 4'(NROUNDS);

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

    state_t       state;
    logic [127:0] st_q, rk_q;
    logic [127:0] sb_p0, nrk_p0;
    logic [127:0] sr, mc, ark;
    logic         start;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            b  = gmul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [3:0] idx);
        logic [7:0]  rcon;
        logic [31:0] t, w0, w1, w2, w3;
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
        t  = t ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

`ifdef AES_LOAD_ABORT_EN
    assign start = load;
`else
    assign start = load && !busy;
`endif

    // Stage p0: SubBytes and next round key, registered during SUB
    always_ff @(posedge clk) begin
        if (state == SUB) begin
            sb_p0  <= sub_bytes(st_q);
            nrk_p0 <= key_expand(rk_q, round - 4'd1);
        end
    end

    // Stage p1: ShiftRows, MixColumns (skipped in the final round), AddRoundKey
    assign sr  = shift_rows(sb_p0);
    assign mc  = (round < LAST) ? mix_columns(sr) : sr;
    assign ark = mc ^ nrk_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            round      <= 4'd0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cyphertext <= '0;
            st_q       <= '0;
            rk_q       <= '0;
        end else if (start) begin
            rk_q  <= key;
            st_q  <= plaintext ^ key;
            round <= 4'd1;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= SUB;
        end else begin
            case (state)
                SUB: state <= MIX;
                MIX: begin
                    st_q <= ark;
                    rk_q <= nrk_p0;
                    if (round == LAST) begin
                        cyphertext <= ark;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        round <= round + 4'd1;
                        state <= SUB;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed and randomized bench for aes_round_ctrl against a byte-array AES-128 model.
module tb_aes_round_ctrl;

    logic         clk;
    logic         reset;
    logic         load;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic [127:0] cyphertext;
    logic         done;
    logic         busy;
    logic [3:0]   round;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] KB  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PB  = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] CB  = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] KC  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PC  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CC  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    aes_round_ctrl #(.NROUNDS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .key        (key),
        .plaintext  (plaintext),
        .cyphertext (cyphertext),
        .done       (done),
        .busy       (busy),
        .round      (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box by walking generator 3 and its inverse together.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row+4*col] = s[row+4*((col+row)%4)];
            for (int col = 0; col < 4; col++) begin
                a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
                if (r < 10) begin
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Control outputs j edges after the accepting edge.
    task automatic check_ctl(input string tag, input int j);
        int er;
        er = (j < 20) ? (j / 2 + 1) : 10;
        chk({tag, ".round"}, 128'(round), 128'(er));
        chk({tag, ".busy"},  128'(busy),  128'(j < 20));
        chk({tag, ".done"},  128'(done),  128'(j >= 20));
    endtask

    task automatic follow(input string tag, input int from, input int to);
        for (int j = from; j <= to; j++) begin
            tick;
            check_ctl(tag, j);
        end
    endtask

    task automatic start(input logic [127:0] k, input logic [127:0] p);
        key       = k;
        plaintext = p;
        load      = 1'b1;
        tick;
        load      = 1'b0;
    endtask

    initial begin
        logic [127:0] rk, rp, rexp;
        build_sbox;

        // Reset wins over a simultaneous load
        reset = 1'b1; load = 1'b1; key = KB; plaintext = PB;
        tick; tick;
        chk("rst.done", 128'(done), 128'(0));
        chk("rst.busy", 128'(busy), 128'(0));
        chk("rst.round", 128'(round), 128'(0));
        chk("rst.ct", cyphertext, 128'(0));
        reset = 1'b0; load = 1'b0;
        tick;
        chk("idle.round", 128'(round), 128'(0));
        chk("idle.busy", 128'(busy), 128'(0));

        // FIPS-197 Appendix B, single load pulse
        start(KB, PB);
        check_ctl("appB", 0);
        follow("appB", 1, 20);
        chk("appB.ct", cyphertext, CB);
        chk("appB.model", cyphertext, model_encrypt(KB, PB));
        tick;
        chk("appB.hold_done", 128'(done), 128'(1));
        chk("appB.hold_ct", cyphertext, CB);

        // FIPS-197 C.1 with inputs scrambled after acceptance
        start(KC, PC);
        key = {$urandom, $urandom, $urandom, $urandom};
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        check_ctl("c1", 0);
        follow("c1", 1, 20);
        chk("c1.ct", cyphertext, CC);

        // Back-to-back blocks
        key = KB; plaintext = PB; load = 1'b1;
        tick;
        check_ctl("b2b0", 0);
        key = KC; plaintext = PC;
`ifdef AES_LOAD_ABORT_EN
        load = 1'b0;
        follow("b2b0", 1, 20);
        load = 1'b1;
`else
        follow("b2b0", 1, 20);
`endif
        chk("b2b0.ct", cyphertext, CB);
        tick;
        check_ctl("b2b1", 0);
`ifdef AES_LOAD_ABORT_EN
        load = 1'b0;
        follow("b2b1", 1, 20);
`else
        follow("b2b1", 1, 19);
        load = 1'b0;
        follow("b2b1", 20, 20);
`endif
        chk("b2b1.ct", cyphertext, CC);
        tick;
        chk("b2b1.hold_done", 128'(done), 128'(1));

        // Reset in round 5
        start(KB, PB);
        follow("rmid", 1, 8);
        chk("rmid.round5", 128'(round), 128'(5));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rmid.done", 128'(done), 128'(0));
        chk("rmid.busy", 128'(busy), 128'(0));
        chk("rmid.round", 128'(round), 128'(0));
        chk("rmid.ct", cyphertext, 128'(0));
        tick;
        chk("rmid.idle_round", 128'(round), 128'(0));
        start(KB, PB);
        check_ctl("rmid.rerun", 0);
        follow("rmid.rerun", 1, 20);
        chk("rmid.rerun_ct", cyphertext, CB);

        // Load pulse in round 3
        start(KB, PB);
        follow("lbusy", 1, 4);
        key = KC; plaintext = PC; load = 1'b1;
        tick;
        load = 1'b0;
`ifdef AES_LOAD_ABORT_EN
        check_ctl("lbusy", 0);
        follow("lbusy", 1, 20);
        chk("lbusy.ct", cyphertext, CC);
`else
        check_ctl("lbusy", 5);
        follow("lbusy", 6, 20);
        chk("lbusy.ct", cyphertext, CB);
`endif

        // Random vectors against the model
        for (int n = 0; n < 4; n++) begin
            rk   = {$urandom, $urandom, $urandom, $urandom};
            rp   = {$urandom, $urandom, $urandom, $urandom};
            rexp = model_encrypt(rk, rp);
            start(rk, rp);
            check_ctl("rnd", 0);
            follow("rnd", 1, 20);
            chk("rnd.ct", cyphertext, rexp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
